// File: rtl/seq_detect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_detect_pkg                                            |
// | Purpose  : Shared types and helpers for the parametrised serial      |
// |            sequence detector (seq_detect_param / seq_window).        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package seq_detect_pkg;

  // Detector state encoding (explicit 2-bit width)
  typedef enum logic [1:0] {
    FILL = 2'b00,
    HUNT = 2'b01,
    HIT  = 2'b10
  } state_e;

  // Largest supported pattern length
  localparam int PAT_W_MAX = 16;

  // Bits needed to hold a fill count of 0..pat_w inclusive
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detect_window.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_window                                                |
// | Purpose  : Serial shift window with saturating fill counter and      |
// |            pattern comparator. Produces the match (hit) and window-  |
// |            full flags for the post-update window contents.           |
// | Options  : SEQ_DETECT_MASK_EN adds a per-bit don't-care MASK.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module seq_window #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1
`ifdef SEQ_DETECT_MASK_EN
  ,
  parameter logic [PAT_W-1:0] MASK  = '1
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ina,
  output logic hit,
  output logic full
);
  import seq_detect_pkg::*;

  localparam int             FW       = fill_width(PAT_W);
  localparam logic [FW-1:0]  FULL_CNT = FW'(PAT_W);

  logic [PAT_W-1:0] shreg_q, shreg_d, shreg_n;
  logic [FW-1:0]    fill_q,  fill_d,  fill_n;
  logic             cmp;

  // Post-sample window, compare, and next-state for shreg/fill
  always_comb begin
    // Newest bit enters at the LSB; the oldest bit falls off the MSB
    shreg_n = (shreg_q << 1) | PAT_W'(ina);
    fill_n  = (fill_q == FULL_CNT) ? fill_q : fill_q + FW'(1);

`ifdef SEQ_DETECT_MASK_EN
    cmp = (((shreg_n ^ PATTERN) & MASK) == '0);
`else
    cmp = (shreg_n == PATTERN);
`endif

    full = (fill_n == FULL_CNT);
    hit  = en && full && cmp;

    shreg_d = shreg_q;
    fill_d  = fill_q;
    if (en) begin
      if (hit && !OVERLAP) begin
        // Non-overlap: a match consumes the whole window
        shreg_d = '0;
        fill_d  = '0;
      end else begin
        shreg_d = shreg_n;
        fill_d  = fill_n;
      end
    end
  end

  // Window state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      fill_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_detect_param                                          |
// | Purpose  : Parametrised serial bit-sequence detector. Pulses dataout |
// |            one cycle after the sample completing PATTERN, keeps a    |
// |            saturating match count, flags busy while hunting.         |
// | Options  : SEQ_DETECT_MASK_EN adds parameter MASK (don't-care bits). |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module seq_detect_param #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
`ifdef SEQ_DETECT_MASK_EN
  ,
  parameter logic [PAT_W-1:0] MASK  = '1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ina,
  output logic             dataout,
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt
);
  import seq_detect_pkg::*;

  logic             hit;
  logic             full;
  state_e           state_q, state_d;
  logic             dataout_q, dataout_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  seq_window #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP)
`ifdef SEQ_DETECT_MASK_EN
    ,
    .MASK    (MASK)
`endif
  ) u_window (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .ina  (ina),
    .hit  (hit),
    .full (full)
  );

  // Next state, output and counter logic
  always_comb begin
    state_d = state_q;
    if (en) begin
      // HIT re-evaluates like HUNT or FILL automatically: in non-overlap
      // mode the window was cleared, so full stays low until refilled.
      if (hit) begin
        state_d = HIT;
      end else if (full) begin
        state_d = HUNT;
      end else begin
        state_d = FILL;
      end
    end

    dataout_d = hit;
    busy_d    = (state_d == HUNT) || (OVERLAP && (state_d == HIT));
    cnt_d     = (hit && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State, registered outputs and saturating counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      dataout_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dataout_q <= dataout_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dataout   = dataout_q;
  assign busy      = busy_q;
  assign match_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_seq_detect_param                                       |
// | Purpose  : Directed self-checking bench for seq_detect_param.        |
// |            Mask instance is built only with SEQ_DETECT_MASK_EN.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic ina = 1'b0;

  always #5 clk = ~clk;

  // dut0: defaults (overlap), dut1: non-overlap, dut2: 2-bit counter
  logic       d0, b0;
  logic [7:0] c0;
  logic       d1, b1;
  logic [7:0] c1;
  logic       d2, b2;
  logic [1:0] c2;

  seq_detect_param dut0 (
    .clk(clk), .rst(rst), .en(en), .ina(ina),
    .dataout(d0), .busy(b0), .match_cnt(c0)
  );

  seq_detect_param #(.OVERLAP(1'b0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .ina(ina),
    .dataout(d1), .busy(b1), .match_cnt(c1)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .ina(ina),
    .dataout(d2), .busy(b2), .match_cnt(c2)
  );

`ifdef SEQ_DETECT_MASK_EN
  logic       d3, b3;
  logic [7:0] c3;
  seq_detect_param #(.MASK(4'b1101)) dut3 (
    .clk(clk), .rst(rst), .en(en), .ina(ina),
    .dataout(d3), .busy(b3), .match_cnt(c3)
  );
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the active edge
  task automatic step(input logic e, input logic b);
    en  = e;
    ina = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    ina = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int t2_in [7] = '{1, 0, 1, 1, 0, 1, 1};
  int t2_e0 [7] = '{0, 0, 0, 1, 0, 0, 1};
  int t2_e1 [7] = '{0, 0, 0, 1, 0, 0, 0};
  int t3_en [8] = '{1, 0, 0, 0, 1, 1, 0, 1};
  int t3_in [8] = '{1, 1, 0, 1, 0, 1, 1, 1};
  int t3_e0 [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  int t6_in [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
  int t6_e  [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    int sat_exp;

    // ---------------- reset state ----------------
    do_reset();
    check_val("rst dataout", d0, 0);
    check_val("rst busy", b0, 0);
    check_val("rst match_cnt", c0, 0);

    // ---------------- basic hit ----------------
    step(1'b1, 1'b1);
    check_val("t1 s1 dataout", d0, 0);
    step(1'b1, 1'b0);
    check_val("t1 s2 dataout", d0, 0);
    step(1'b1, 1'b1);
    check_val("t1 s3 dataout", d0, 0);
    check_val("t1 s3 busy", b0, 0);
    step(1'b1, 1'b1);
    check_val("t1 s4 dataout", d0, 1);
    check_val("t1 s4 dataout nonovl", d1, 1);
    check_val("t1 s4 match_cnt", c0, 1);
    check_val("t1 s4 busy ovl", b0, 1);
    check_val("t1 s4 busy nonovl", b1, 0);
    step(1'b1, 1'b0);
    check_val("t1 s5 dataout width", d0, 0);
    check_val("t1 s5 busy ovl", b0, 1);
    check_val("t1 s5 busy nonovl", b1, 0);
    check_val("t1 s5 match_cnt", c0, 1);

    // ---------------- full window without match ----------------
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check_val("t1b busy ovl", b0, 1);
    check_val("t1b busy nonovl", b1, 1);
    check_val("t1b dataout", d0, 0);

    // ---------------- overlap vs non-overlap ----------------
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, t2_in[i][0]);
      check_val($sformatf("t2 ovl dataout[%0d]", i), d0, t2_e0[i]);
      check_val($sformatf("t2 nonovl dataout[%0d]", i), d1, t2_e1[i]);
    end
    check_val("t2 ovl match_cnt", c0, 2);
    check_val("t2 nonovl match_cnt", c1, 1);

    // ---------------- en gaps ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(t3_en[i][0], t3_in[i][0]);
      check_val($sformatf("t3 dataout[%0d]", i), d0, t3_e0[i]);
      if (i < 7) check_val($sformatf("t3 busy[%0d]", i), b0, 0);
    end
    check_val("t3 match_cnt", c0, 1);
    step(1'b0, 1'b1);
    check_val("t3 hold dataout", d0, 0);
    check_val("t3 hold busy", b0, 1);
    check_val("t3 hold match_cnt", c0, 1);

    // ---------------- reset mid-fill ----------------
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check_val("t4 async rst dataout", d0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b1);
    check_val("t4 after rst dataout", d0, 0);
    check_val("t4 after rst match_cnt", c0, 0);
    step(1'b1, 1'b0);
    check_val("t4 f2 dataout", d0, 0);
    step(1'b1, 1'b1);
    check_val("t4 f3 dataout", d0, 0);
    step(1'b1, 1'b1);
    check_val("t4 f4 dataout", d0, 1);
    check_val("t4 match_cnt", c0, 1);

    // ---------------- counter saturation ----------------
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check_val($sformatf("t5 pre dataout[%0d]", k), d2, 0);
      step(1'b1, 1'b1);
      sat_exp = (k + 1 > 3) ? 3 : k + 1;
      check_val($sformatf("t5 dataout[%0d]", k), d2, 1);
      check_val($sformatf("t5 match_cnt[%0d]", k), c2, sat_exp);
      step(1'b1, 1'b0);
      check_val($sformatf("t5 gap dataout[%0d]", k), d2, 0);
    end
    check_val("t5 wide match_cnt", c0, 5);

`ifdef SEQ_DETECT_MASK_EN
    // ---------------- masked compare ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, t6_in[i][0]);
      check_val($sformatf("t6 mask dataout[%0d]", i), d3, t6_e[i]);
    end
    check_val("t6 mask match_cnt", c3, 2);
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check_val("t6 mask 0011 dataout", d3, 0);
    check_val("t6 mask 0011 match_cnt", c3, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
